// File: rtl/cook_sequencer_pkg.sv
// Shared state encodings, default parameters and power-level helper for cook_sequencer.
package cook_sequencer_pkg;

    localparam int unsigned BEEP_SECS_DEF   = 3;
    localparam int unsigned DUTY_WINDOW_DEF = 10;
    localparam int unsigned MAX_POWER       = 10;
    localparam int unsigned POWER_W         = 4;
    localparam int unsigned STATE_W         = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_COOK  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } cook_state_e;

    // Out-of-range power requests (0 or above 10) run at full power.
    function automatic logic [POWER_W-1:0] eff_power(input logic [POWER_W-1:0] pl);
        if (pl == '0 || pl > POWER_W'(MAX_POWER)) begin
            return POWER_W'(MAX_POWER);
        end
        return pl;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Falling-edge detector for an active-low, already-synchronous button level.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn_n_i,
    output logic fall_c_o
);

    logic prev_q;

    // Released level (1) after reset so a button held through reset does not fire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= btn_n_i;
        end
    end

    assign fall_c_o = prev_q & ~btn_n_i;

endmodule

// File: rtl/cook_sequencer.sv
// Microwave cook sequencer: keypad entry, cook/pause/done control and magnetron drive.
// Define POWER_LEVEL_EN to duty-cycle mag_on by power_level over a DUTY_WINDOW-tick window.
module cook_sequencer
    import cook_sequencer_pkg::*;
#(
    parameter int unsigned BEEP_SECS   = BEEP_SECS_DEF,
    parameter int unsigned DUTY_WINDOW = DUTY_WINDOW_DEF
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               tick_1hz,
    input  logic               start_n,
    input  logic               stop_n,
    input  logic               door_closed,
    input  logic               key_valid,
    input  logic               zero,
    input  logic [POWER_W-1:0] power_level,
    output logic               load_n,
    output logic               count_en,
    output logic               mag_on,
    output logic               beep,
    output logic [STATE_W-1:0] state
);

    localparam int unsigned BEEP_W = (BEEP_SECS > 0) ? $clog2(BEEP_SECS + 1) : 1;

    cook_state_e       state_q, state_d;
    logic [BEEP_W-1:0] beep_cnt_q, beep_cnt_d;
    logic              count_en_q, beep_q, mag_q, mag_d;
    logic              load_c, start_ev, stop_ev;

    btn_edge u_start_edge (
        .clk      (clk),
        .rst      (clear),
        .btn_n_i  (start_n),
        .fall_c_o (start_ev)
    );

    btn_edge u_stop_edge (
        .clk      (clk),
        .rst      (clear),
        .btn_n_i  (stop_n),
        .fall_c_o (stop_ev)
    );

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q    <= ST_IDLE;
            beep_cnt_q <= '0;
            count_en_q <= 1'b0;
            beep_q     <= 1'b0;
            mag_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            beep_cnt_q <= beep_cnt_d;
            count_en_q <= (state_d == ST_COOK);
            beep_q     <= (state_d == ST_DONE);
            mag_q      <= mag_d;
        end
    end

    // Next state; priority door open > stop > zero > start > key.
    always_comb begin
        state_d    = state_q;
        load_c     = 1'b0;
        beep_cnt_d = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (key_valid) begin
                    state_d = ST_ENTRY;
                    load_c  = 1'b1;
                end
            end
            ST_ENTRY: begin
                if (stop_ev) begin
                    state_d = ST_IDLE;
                end else if (start_ev && door_closed && !zero) begin
                    state_d = ST_COOK;
                end else if (key_valid) begin
                    load_c = 1'b1;
                end
            end
            ST_COOK: begin
                if (!door_closed || stop_ev) begin
                    state_d = ST_PAUSE;
                end else if (zero) begin
                    state_d = ST_DONE;
                end
            end
            ST_PAUSE: begin
                if (stop_ev) begin
                    state_d = ST_IDLE;
                end else if (start_ev && door_closed) begin
                    state_d = ST_COOK;
                end
            end
            ST_DONE: begin
                beep_cnt_d = beep_cnt_q;
                if (tick_1hz && beep_cnt_q != BEEP_W'(BEEP_SECS)) begin
                    beep_cnt_d = beep_cnt_q + BEEP_W'(1);
                end
                if (start_ev || stop_ev || key_valid) begin
                    state_d = ST_IDLE;
                end else if (beep_cnt_d == BEEP_W'(BEEP_SECS)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef POWER_LEVEL_EN
    localparam int unsigned DUTY_W = (DUTY_WINDOW > 1) ? $clog2(DUTY_WINDOW) : 1;

    logic [DUTY_W-1:0] duty_q, duty_d;

    // Phase restarts on a fresh cook, holds across pause/resume.
    always_comb begin
        duty_d = duty_q;
        if (state_q == ST_ENTRY && state_d == ST_COOK) begin
            duty_d = '0;
        end else if (state_q == ST_COOK && tick_1hz) begin
            duty_d = (duty_q == DUTY_W'(DUTY_WINDOW - 1)) ? '0 : duty_q + DUTY_W'(1);
        end
        mag_d = (state_d == ST_COOK) && (32'(duty_d) < 32'(eff_power(power_level)));
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            duty_q <= '0;
        end else begin
            duty_q <= duty_d;
        end
    end
`else
    localparam int unsigned unused_duty_window = DUTY_WINDOW;
    logic unused_power;

    assign unused_power = ^power_level;
    assign mag_d        = (state_d == ST_COOK);
`endif

    // Door gating keeps the magnetron off in the very cycle the door opens.
    assign mag_on   = mag_q & door_closed;
    assign load_n   = ~(load_c & ~clear);
    assign count_en = count_en_q;
    assign beep     = beep_q;
    assign state    = state_q;

endmodule

// File: tb/tb_cook_sequencer.sv
// Randomized and directed self-checking bench for cook_sequencer against a behavioural model.
module tb_cook_sequencer;

    localparam int BEEP = 3;
    localparam int DW   = 10;
    localparam int S_IDLE = 0, S_ENTRY = 1, S_COOK = 2, S_PAUSE = 3, S_DONE = 4;

    logic       clk = 1'b0;
    logic       clear, tick_1hz, start_n, stop_n, door_closed, key_valid, zero;
    logic [3:0] power_level;
    logic       load_n, count_en, mag_on, beep;
    logic [2:0] state;

    int n_checks = 0;
    int n_errors = 0;
    int m_state, m_ticks, m_beep, loads;
    bit m_prev_start, m_prev_stop, m_mag;

    always #5 clk = ~clk;

    cook_sequencer #(.BEEP_SECS(BEEP), .DUTY_WINDOW(DW)) dut (
        .clk         (clk),
        .clear       (clear),
        .tick_1hz    (tick_1hz),
        .start_n     (start_n),
        .stop_n      (stop_n),
        .door_closed (door_closed),
        .key_valid   (key_valid),
        .zero        (zero),
        .power_level (power_level),
        .load_n      (load_n),
        .count_en    (count_en),
        .mag_on      (mag_on),
        .beep        (beep),
        .state       (state)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

`ifdef POWER_LEVEL_EN
    function automatic int eff_power_m(input int p);
        return (p == 0 || p > 10) ? 10 : p;
    endfunction
`endif

    task automatic model_reset();
        m_state      = S_IDLE;
        m_prev_start = 1'b1;
        m_prev_stop  = 1'b1;
        m_ticks      = 0;
        m_beep       = 0;
        m_mag        = 1'b0;
    endtask

    task automatic idle_in();
        start_n   = 1'b1;
        stop_n    = 1'b1;
        key_valid = 1'b0;
        tick_1hz  = 1'b0;
    endtask

    // Called at a falling edge with inputs already applied; checks, advances model, crosses one rising edge.
    task automatic step();
        bit se, te, ld;
        int nxt;
        #1;
        check_eq("state", int'(state), m_state);
        check_eq("count_en", int'(count_en), int'(m_state == S_COOK));
        check_eq("beep", int'(beep), int'(m_state == S_DONE));
        check_eq("mag_on", int'(mag_on), int'(m_mag && door_closed));
        se  = m_prev_start && !start_n;
        te  = m_prev_stop && !stop_n;
        nxt = m_state;
        ld  = 1'b0;
        case (m_state)
            S_IDLE: if (key_valid) begin nxt = S_ENTRY; ld = 1'b1; end
            S_ENTRY: begin
                if (te) nxt = S_IDLE;
                else if (se && door_closed && !zero) begin nxt = S_COOK; m_ticks = 0; end
                else if (key_valid) ld = 1'b1;
            end
            S_COOK: begin
                if (tick_1hz) m_ticks++;
                if (!door_closed || te) nxt = S_PAUSE;
                else if (zero) begin nxt = S_DONE; m_beep = 0; end
            end
            S_PAUSE: begin
                if (te) nxt = S_IDLE;
                else if (se && door_closed) nxt = S_COOK;
            end
            S_DONE: begin
                if (tick_1hz && m_beep < BEEP) m_beep++;
                if (se || te || key_valid || m_beep >= BEEP) nxt = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
        check_eq("load_n", int'(load_n), int'(!ld));
        if (!load_n) loads++;
        m_prev_start = start_n;
        m_prev_stop  = stop_n;
        m_state      = nxt;
`ifdef POWER_LEVEL_EN
        m_mag = (nxt == S_COOK) && ((m_ticks % DW) < eff_power_m(int'(power_level)));
`else
        m_mag = (nxt == S_COOK);
`endif
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) begin
            idle_in();
            step();
        end
    endtask

    task automatic press_key();
        key_valid = 1'b1; step();
        key_valid = 1'b0; step();
    endtask

    task automatic press_start();
        start_n = 1'b0; step(); step();
        start_n = 1'b1; step();
    endtask

    task automatic one_tick();
        tick_1hz = 1'b1; step();
        tick_1hz = 1'b0; step();
    endtask

    initial begin
        clear = 1'b1;
        idle_in();
        door_closed = 1'b1;
        zero        = 1'b0;
        power_level = 4'd10;
        key_valid   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("rst_state", int'(state), S_IDLE);
        check_eq("rst_load_n", int'(load_n), 1);
        check_eq("rst_count_en", int'(count_en), 0);
        check_eq("rst_mag_on", int'(mag_on), 0);
        check_eq("rst_beep", int'(beep), 0);
        key_valid = 1'b0;
        clear     = 1'b0;
        model_reset();

        // Three digits then start at full power.
        loads = 0;
        repeat (3) press_key();
        press_start();
        check_eq("entry_loads", loads, 3);
        check_eq("entry_cook_state", int'(state), S_COOK);
        check_eq("entry_count_en", int'(count_en), 1);
        check_eq("entry_mag_full", int'(mag_on), 1);

        // Power 3 over two duty windows.
        power_level = 4'd3;
        steps(1);
        for (int k = 0; k < 20; k++) begin
`ifdef POWER_LEVEL_EN
            check_eq("duty_pattern", int'(mag_on), int'((k % 10) < 3));
`else
            check_eq("duty_pattern", int'(mag_on), 1);
`endif
            one_tick();
        end

        // Door opens at duty count 1, then resume.
        one_tick();
        door_closed = 1'b0;
        step();
        check_eq("door_pause_state", int'(state), S_PAUSE);
        check_eq("door_pause_mag", int'(mag_on), 0);
        door_closed = 1'b1;
        steps(1);
        press_start();
        check_eq("resume_state", int'(state), S_COOK);
        check_eq("resume_mag", int'(mag_on), 1);
        one_tick();
        one_tick();
`ifdef POWER_LEVEL_EN
        check_eq("resume_phase_off", int'(mag_on), 0);
`else
        check_eq("resume_phase_off", int'(mag_on), 1);
`endif

        // Timer reaches zero: beep for exactly BEEP ticks.
        zero = 1'b1;
        step();
        for (int t = 0; t < BEEP; t++) begin
            check_eq("done_state", int'(state), S_DONE);
            check_eq("done_beep", int'(beep), 1);
            one_tick();
        end
        check_eq("done_to_idle", int'(state), S_IDLE);
        check_eq("done_beep_off", int'(beep), 0);
        zero = 1'b0;

        // Start and stop in the same clk during entry.
        press_key();
        start_n = 1'b0;
        stop_n  = 1'b0;
        step();
        check_eq("both_btn_state", int'(state), S_IDLE);
        steps(2);
        check_eq("both_btn_no_cook", int'(count_en), 0);

        // Async clear mid-cook.
        power_level = 4'd10;
        press_key();
        press_start();
        check_eq("pre_clear_mag", int'(mag_on), 1);
        #2 clear = 1'b1;
        #1;
        check_eq("clear_mag_async", int'(mag_on), 0);
        check_eq("clear_state", int'(state), S_IDLE);
        check_eq("clear_count_en", int'(count_en), 0);
        check_eq("clear_beep", int'(beep), 0);
        check_eq("clear_load_n", int'(load_n), 1);
        @(negedge clk);
        clear = 1'b0;
        model_reset();

        for (int i = 0; i < 3000; i++) begin
            start_n     = ($urandom_range(0, 5) != 0);
            stop_n      = ($urandom_range(0, 11) != 0);
            door_closed = ($urandom_range(0, 15) != 0);
            key_valid   = ($urandom_range(0, 6) == 0);
            zero        = ($urandom_range(0, 40) == 0);
            tick_1hz    = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 63) == 0) power_level = 4'($urandom_range(0, 15));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cook_sequencer.md
COOK_SEQUENCER -- requirements
Module: cook_sequencer

Interface
REQ-001 Parameter BEEP_SECS, default 3: number of 1 Hz ticks the beep output stays high after a cook completes.
REQ-002 Parameter DUTY_WINDOW, default 10: length, in ticks, of one power-level duty window.
REQ-003 clk  in  1  single system clock; all state updates on rising edge.
REQ-004 clear  in  1  reset, asynchronous, active-high.
REQ-005 tick_1hz  in  1  one-clk-wide pulse at 1 Hz from the timer input path.
REQ-006 start_n  in  1  start button, active-low level, already synchronous to clk.
REQ-007 stop_n  in  1  stop/pause button, active-low level, already synchronous to clk.
REQ-008 door_closed  in  1  1 = door closed.
REQ-009 key_valid  in  1  one-clk pulse, a keypad digit is present.
REQ-010 zero  in  1  timer count reads 00:00.
REQ-011 power_level  in  4  magnetron power, 1..10; 0 and values above 10 are treated as 10.
REQ-012 load_n  out  1  active-low shift/load strobe to timer, one clk wide.
REQ-013 count_en  out  1  timer decrement enable.
REQ-014 mag_on  out  1  magnetron drive.
REQ-015 beep  out  1  completion buzzer.
REQ-016 state  out  3  current FSM state encoding, for display/debug.

Function
REQ-017 FSM states are IDLE, ENTRY, COOK, PAUSE and DONE; state SHALL be registered and output directly.
REQ-018 Button events SHALL be the falling edges of start_n/stop_n, detected with one internal register stage each; a held button SHALL produce exactly one event.
REQ-019 IDLE: on key_valid -> ENTRY, and load_n SHALL pulse low in the same clk as key_valid.
REQ-020 ENTRY: each key_valid SHALL produce one load_n pulse; stop event -> IDLE; start event with door_closed=1 and zero=0 -> COOK; start event with door open or zero=1 is ignored.
REQ-021 COOK: count_en=1; a stop event or door_closed=0 -> PAUSE in the next clk; zero=1 -> DONE.
REQ-022 PAUSE: count_en=0 and mag_on=0; start event with door_closed=1 -> COOK with the duty phase preserved; stop event -> IDLE; key_valid is ignored.
REQ-023 DONE: count_en=0, mag_on=0, beep=1 for BEEP_SECS ticks, then -> IDLE; any start, stop or key event ends the beep early and moves to IDLE; key_valid in DONE additionally goes through IDLE to ENTRY on the next key only.
REQ-024 Priority within one clk: door_closed=0 > stop event > zero > start event > key_valid.
REQ-025 Duty counter: modulo-DUTY_WINDOW count advancing on tick_1hz only in COOK; mag_on=1 in COOK while counter < effective power level; the counter resets to 0 on entry to COOK from ENTRY.
REQ-026 mag_on SHALL be registered, and SHALL never be 1 in the same clk in which door_closed=0 is sampled (combinational gating by door_closed permitted).
REQ-027 The beep counter SHALL be width clog2(BEEP_SECS+1) and SHALL saturate, never wrap.

Reset
REQ-028 While clear=1: state=IDLE, load_n=1, count_en=0, mag_on=0, beep=0, duty and beep counters 0, edge registers set to 1 (released).
REQ-029 clear asserted mid-COOK SHALL force mag_on=0 asynchronously, without waiting for clk.

Configuration
REQ-030 Macro POWER_LEVEL_EN: when defined, duty cycling per REQ-025 applies.
REQ-031 When POWER_LEVEL_EN is undefined, power_level is ignored, the duty counter is not built, and mag_on equals (state==COOK and door_closed).

Structure
REQ-032 A shared package/header SHALL hold the state encodings (IDLE=0, ENTRY=1, COOK=2, PAUSE=3, DONE=4) and the default parameter constants.
REQ-033 One sub-module, btn_edge, SHALL implement the falling-edge detector of REQ-018 and SHALL be instantiated twice.

Verification
REQ-034 key_valid x3, start, door_closed=1 -> three load_n pulses; state COOK; count_en=1; mag_on=1 with power 10.
REQ-035 power_level=3 in COOK for 20 ticks -> mag_on high for ticks 0-2 and 10-12 and low elsewhere.
REQ-036 door_closed drops in COOK at duty count 1 -> next clk PAUSE, mag_on=0; close door + start -> COOK, mag_on resumes at count 1.
REQ-037 zero rises in COOK -> DONE, beep high exactly 3 ticks, then IDLE.
REQ-038 start and stop falling in the same clk during ENTRY -> IDLE; no COOK.
REQ-039 clear pulsed mid-COOK between clk edges -> mag_on low immediately; all outputs at reset values.
